// File: rtl/lcd_power_sequencer.sv
// rtl/lcd_power_sequencer.sv - LCD panel power-up/power-down sequencer
// All state advances on the falling edge of clk_out. Every output is registered.
module lcd_power_sequencer #(
   parameter int T_TFT     = 4,
   parameter int T_SIG     = 3,
   parameter int T_LED_OFF = 2,
   parameter int T_TFT_OFF = 5,
   parameter int T_OFF_MIN = 6,
   parameter int CNT_W     = 8
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       lcdoff,
   output logic       TFT_en,
   output logic       de_en,
   output logic       disp_en,
   output logic       rgb_en,
   output logic       pixel_en,
   output logic       en_sync,
   output logic       led_en,
   output logic       lcd_ready,
   output logic       busy,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PWR_UP = 3'd1,
      S_SIG_ON = 3'd2,
      S_ON     = 3'd3,
      S_LED_DN = 3'd4,
      S_SIG_DN = 3'd5
   } state_t;

   // The delay counter is loaded with T-1 so a state spans exactly T edges.
   localparam logic [CNT_W-1:0] LD_TFT     = CNT_W'(T_TFT - 1);
   localparam logic [CNT_W-1:0] LD_SIG     = CNT_W'(T_SIG - 1);
   localparam logic [CNT_W-1:0] LD_LED_OFF = CNT_W'(T_LED_OFF - 1);
   localparam logic [CNT_W-1:0] LD_TFT_OFF = CNT_W'(T_TFT_OFF - 1);
   localparam logic [CNT_W-1:0] LD_OFF     = CNT_W'(T_OFF_MIN);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic             OFF_HOLD   = (T_OFF_MIN != 0);

   state_t           state;
   logic [CNT_W-1:0] dly_cnt;
   logic [CNT_W-1:0] off_cnt;
   logic             sig;

   // Output image of a state: {TFT_en, SIG, led_en, lcd_ready, busy}.
   function automatic logic [4:0] drive(input state_t s, input logic hold);
      case (s)
         S_OFF:    drive = {4'b0000, hold};
         S_PWR_UP: drive = 5'b10001;
         S_SIG_ON: drive = 5'b11001;
         S_ON:     drive = 5'b11110;
         S_LED_DN: drive = 5'b11001;
         S_SIG_DN: drive = 5'b10001;
         default:  drive = 5'b00000;
      endcase
   endfunction

   always_ff @(negedge clk_out or negedge rst) begin
      if (!rst) begin
         state   <= S_OFF;
         dly_cnt <= CNT_ZERO;
         off_cnt <= CNT_ZERO;
         {TFT_en, sig, led_en, lcd_ready, busy} <= 5'b00000;
      end else begin
         case (state)
            S_OFF: begin
               if (off_cnt != CNT_ZERO) begin
                  off_cnt <= off_cnt - CNT_ONE;
                  busy    <= (off_cnt != CNT_ONE);
               end else if (!lcdoff) begin
                  state   <= S_PWR_UP;
                  dly_cnt <= LD_TFT;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_PWR_UP, 1'b0);
               end
            end
            S_PWR_UP, S_SIG_ON: begin
               // Abort before the backlight is on: SIG is dropped now, TFT later.
               if (lcdoff) begin
                  state   <= S_SIG_DN;
                  dly_cnt <= LD_TFT_OFF;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_SIG_DN, 1'b0);
               end else if (dly_cnt != CNT_ZERO) begin
                  dly_cnt <= dly_cnt - CNT_ONE;
               end else if (state == S_PWR_UP) begin
                  state   <= S_SIG_ON;
                  dly_cnt <= LD_SIG;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_SIG_ON, 1'b0);
               end else begin
                  state   <= S_ON;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_ON, 1'b0);
               end
            end
            S_ON: begin
               if (lcdoff) begin
                  state   <= S_LED_DN;
                  dly_cnt <= LD_LED_OFF;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_LED_DN, 1'b0);
               end
            end
            S_LED_DN: begin
               if (dly_cnt != CNT_ZERO) begin
                  dly_cnt <= dly_cnt - CNT_ONE;
               end else begin
                  state   <= S_SIG_DN;
                  dly_cnt <= LD_TFT_OFF;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_SIG_DN, 1'b0);
               end
            end
            S_SIG_DN: begin
               if (dly_cnt != CNT_ZERO) begin
                  dly_cnt <= dly_cnt - CNT_ONE;
               end else begin
                  state   <= S_OFF;
                  off_cnt <= LD_OFF;
                  {TFT_en, sig, led_en, lcd_ready, busy} <= drive(S_OFF, OFF_HOLD);
               end
            end
            default: begin
               state   <= S_OFF;
               dly_cnt <= CNT_ZERO;
               off_cnt <= CNT_ZERO;
               {TFT_en, sig, led_en, lcd_ready, busy} <= 5'b00000;
            end
         endcase
      end
   end

   assign de_en    = sig;
   assign disp_en  = sig;
   assign rgb_en   = sig;
   assign pixel_en = sig;
   assign en_sync  = sig;
   assign state_o  = state;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// tb/tb_lcd_power_sequencer.sv - directed bench for lcd_power_sequencer
// Snapshot byte: {TFT_en, SIG, led_en, lcd_ready, busy, state_o[2:0]}.
module tb_lcd_power_sequencer;

   typedef logic [7:0] vec_q[$];

   logic clk_out = 1'b0;
   always #5 clk_out = ~clk_out;

   logic       rst_a, lcdoff_a, rst_b, lcdoff_b;
   logic       tft_a, de_a, disp_a, rgb_a, pix_a, sync_a, led_a, rdy_a, busy_a;
   logic       tft_b, de_b, disp_b, rgb_b, pix_b, sync_b, led_b, rdy_b, busy_b;
   logic [2:0] st_a, st_b;

   int checks = 0;
   int errors = 0;

   lcd_power_sequencer dut_a (
      .clk_out(clk_out), .rst(rst_a), .lcdoff(lcdoff_a),
      .TFT_en(tft_a), .de_en(de_a), .disp_en(disp_a), .rgb_en(rgb_a),
      .pixel_en(pix_a), .en_sync(sync_a), .led_en(led_a),
      .lcd_ready(rdy_a), .busy(busy_a), .state_o(st_a)
   );

   lcd_power_sequencer #(
      .T_TFT(1), .T_SIG(1), .T_LED_OFF(1), .T_TFT_OFF(1), .T_OFF_MIN(0), .CNT_W(8)
   ) dut_b (
      .clk_out(clk_out), .rst(rst_b), .lcdoff(lcdoff_b),
      .TFT_en(tft_b), .de_en(de_b), .disp_en(disp_b), .rgb_en(rgb_b),
      .pixel_en(pix_b), .en_sync(sync_b), .led_en(led_b),
      .lcd_ready(rdy_b), .busy(busy_b), .state_o(st_b)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] snap(input bit sel);
      if (sel) return {tft_b, de_b, led_b, rdy_b, busy_b, st_b};
      return {tft_a, de_a, led_a, rdy_a, busy_a, st_a};
   endfunction

   // Advance one active (falling) edge, then sample on the following rising edge.
   task automatic step();
      @(negedge clk_out);
      @(posedge clk_out);
      check("sig_tie_a", {4'b0, disp_a, rgb_a, pix_a, sync_a}, {4'b0, {4{de_a}}});
      check("sig_tie_b", {4'b0, disp_b, rgb_b, pix_b, sync_b}, {4'b0, {4{de_b}}});
      check("order_a", {6'b0, led_a & ~de_a, de_a & ~tft_a}, 8'h00);
      check("order_b", {6'b0, led_b & ~de_b, de_b & ~tft_b}, 8'h00);
   endtask

   task automatic run(input bit sel, input string tag, input vec_q exp);
      foreach (exp[i]) begin
         step();
         check($sformatf("%s[%0d]", tag, i), snap(sel), exp[i]);
      end
   endtask

   vec_q exp_pu, exp_pu6, exp_pu_rest, exp_sd_pulse, exp_sd_hold, exp_abort;

   initial begin
      exp_pu       = {8'h89, 8'h89, 8'h89, 8'h89, 8'hCA, 8'hCA, 8'hCA, 8'hF3, 8'hF3};
      exp_pu6      = {8'h89, 8'h89, 8'h89, 8'h89, 8'hCA, 8'hCA};
      exp_pu_rest  = {8'h89, 8'h89, 8'h89, 8'hCA, 8'hCA, 8'hCA, 8'hF3};
      exp_sd_pulse = {8'hCC, 8'h8D, 8'h8D, 8'h8D, 8'h8D, 8'h8D,
                      8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h89};
      exp_sd_hold  = {8'hCC, 8'hCC, 8'h8D, 8'h8D, 8'h8D, 8'h8D, 8'h8D,
                      8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
      exp_abort    = {8'h8D, 8'h8D, 8'h8D, 8'h8D, 8'h8D,
                      8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};

      rst_a = 1'b0; lcdoff_a = 1'b0;
      rst_b = 1'b0; lcdoff_b = 1'b0;
      repeat (3) @(posedge clk_out);
      check("reset_a", snap(0), 8'h00);
      check("reset_b", snap(1), 8'h00);

      // Power-up from reset release; edges 1..9.
      rst_a = 1'b1;
      run(0, "pu", exp_pu);

      // One-cycle lcdoff pulse in ON: full shutdown, re-power 7 edges after OFF.
      lcdoff_a = 1'b1;
      step();
      check("pulse_n", snap(0), 8'hCC);
      lcdoff_a = 1'b0;
      run(0, "pulse", exp_sd_pulse);
      run(0, "pu_rest", exp_pu_rest);

      // Held lcdoff in ON: stays OFF and idle after the hold window.
      lcdoff_a = 1'b1;
      run(0, "hold", exp_sd_hold);

      // Asynchronous reset in the middle of SIG_ON.
      lcdoff_a = 1'b0;
      run(0, "pu6", exp_pu6);
      #2 rst_a = 1'b0;
      #1 check("async_rst", snap(0), 8'h00);
      @(posedge clk_out);
      rst_a = 1'b1;
      run(0, "pu_again", exp_pu);

      // Abort during PWR_UP: SIG never rises, TFT drops at edge 7.
      rst_a = 1'b0;
      step();
      rst_a = 1'b1;
      step();
      check("abort_e1", snap(0), 8'h89);
      lcdoff_a = 1'b1;
      run(0, "abort", exp_abort);

      // Minimum-delay instance: one edge per step, immediate re-power.
      rst_a = 1'b0;
      rst_b = 1'b1;
      run(1, "sw_up", {8'h89, 8'hCA, 8'hF3, 8'hF3});
      lcdoff_b = 1'b1;
      run(1, "sw_dn", {8'hCC, 8'h8D, 8'h00, 8'h00});
      lcdoff_b = 1'b0;
      run(1, "sw_re", {8'h89});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_power_sequencer.md
LCD_POWER_SEQUENCER -- requirements
Module: lcd_power_sequencer

Interface
REQ-001 SHALL have parameter T_TFT, default 4: negedges between TFT_en rise and signal-enable rise, range 1..2^CNT_W-1.
REQ-002 SHALL have parameter T_SIG, default 3: negedges between signal-enable rise and led_en rise, range 1..2^CNT_W-1.
REQ-003 SHALL have parameter T_LED_OFF, default 2: negedges between led_en fall and signal-enable fall, range 1..2^CNT_W-1.
REQ-004 SHALL have parameter T_TFT_OFF, default 5: negedges between signal-enable fall and TFT_en fall, range 1..2^CNT_W-1.
REQ-005 SHALL have parameter T_OFF_MIN, default 6: minimum negedges spent in OFF before re-power, range 0..2^CNT_W-1.
REQ-006 SHALL have parameter CNT_W, default 8: width of the delay counter and the off counter.
REQ-007 SHALL have ports:
  - clk_out  in  1  clock; all state updates on its falling edge.
  - rst  in  1  asynchronous, active-low reset.
  - lcdoff  in  1  level; 1 = power down request, 0 = power up request.
  - TFT_en  out  1  panel supply enable.
  - de_en, disp_en, rgb_en, pixel_en, en_sync  out  1 each  signal enables, always driven identically, collectively "SIG".
  - led_en  out  1  backlight enable.
  - lcd_ready  out  1  panel fully on.
  - busy  out  1  sequence in progress or off-hold active.
  - state_o  out  3  current state encoding, for debug.

Function
REQ-008 SHALL implement states OFF=0, PWR_UP=1, SIG_ON=2, ON=3, LED_DN=4, SIG_DN=5; encodings 6-7 SHALL return to OFF on the next edge with all outputs 0.
REQ-009 Each timed state SHALL load its delay counter on entry and occupy exactly its parameter's count of negedges unless aborted:
  - PWR_UP: T_TFT
  - SIG_ON: T_SIG
  - LED_DN: T_LED_OFF
  - SIG_DN: T_TFT_OFF
REQ-010 Outputs SHALL be registered and SHALL take their new values on the same edge that enters the state, with no combinational path from lcdoff.
REQ-011 TFT_en=1 in every state except OFF; SIG=1 in SIG_ON, ON and LED_DN; led_en=1 only in ON; lcd_ready=1 only in ON.
REQ-012 busy=1 in PWR_UP, SIG_ON, LED_DN and SIG_DN, and in OFF while the off counter is nonzero; otherwise busy=0.
REQ-013 OFF -> PWR_UP when lcdoff=0 and the off counter is 0; the off counter SHALL decrement once per edge while it is nonzero.
REQ-014 PWR_UP -> SIG_DN on any edge where lcdoff=1 (abort; SIG never asserts); otherwise PWR_UP -> SIG_ON at delay expiry.
REQ-015 SIG_ON -> SIG_DN on any edge where lcdoff=1 (abort; led_en never asserts); otherwise SIG_ON -> ON at delay expiry.
REQ-016 ON SHALL be held while lcdoff=0; ON -> LED_DN on the first edge where lcdoff=1.
REQ-017 LED_DN -> SIG_DN and SIG_DN -> OFF at delay expiry; lcdoff changes SHALL be ignored in both states, so a started shutdown always completes.
REQ-018 Entering OFF SHALL load the off counter with T_OFF_MIN; with T_OFF_MIN=0, re-power MAY start on the next edge.
REQ-019 The power-down order SHALL always be led_en, then SIG, then TFT_en, and never any other order; any transition that would violate this order is forbidden.

Reset
REQ-020 While rst=0, the block SHALL immediately, without a clock edge, hold: state OFF, both counters 0, every output 0.
REQ-021 After rst rises with lcdoff=0, the first negedge SHALL enter PWR_UP; an rst assertion mid-sequence SHALL drop all enables simultaneously.

Verification (default parameters; edges counted from rst release)
REQ-022 lcdoff=0 -> TFT_en=1 at edge 1, SIG=1 at edge 5, led_en=1 and lcd_ready=1 at edge 8, busy=0 from edge 8.
REQ-023 In ON, lcdoff=1 sampled at edge N -> led_en=0 at N, SIG=0 at N+2, TFT_en=0 at N+7, then busy=1 until the off counter reaches 0 at N+13.
REQ-024 lcdoff=1 sampled at edge 2 (PWR_UP) -> SIG never rises, TFT_en=0 at edge 7.
REQ-025 One-cycle lcdoff pulse in ON -> full shutdown completes; TFT_en re-rises exactly 7 edges after OFF entry (T_OFF_MIN hold plus one).
REQ-026 rst driven low mid-SIG_ON, between clock edges -> all outputs 0 and state_o=0 immediately; after release, the REQ-022 timing repeats.
REQ-027 Parameter sweep with T_TFT=T_SIG=T_LED_OFF=T_TFT_OFF=1 and T_OFF_MIN=0 -> one edge per step, and the REQ-019 ordering holds.
